// File: rtl/decode_stage.sv
// decode_stage: splits raw instruction words into registered fields behind a
// 2-entry skid buffer with valid/ready handshakes, flush and a decode counter.
module decode_stage #(
  parameter int OPC_W   = 5,
  parameter int REG_W   = 4,
  parameter int PAD_W   = 2,
  parameter int XLEN    = 16,
  parameter int NUM_OPS = 20,
  parameter int CNT_W   = 16,
  localparam int INSTR_W = OPC_W + 3*REG_W + PAD_W,
  localparam int IMM_W   = 2*REG_W + PAD_W,
  localparam int ADDR_W  = INSTR_W - OPC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               imm_signed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [XLEN-1:0]    imm,
  output logic [ADDR_W-1:0]  addr,
  output logic               illegal,
  output logic [CNT_W-1:0]   dec_count
);
  localparam int B = OPC_W + 3*REG_W + XLEN + ADDR_W + 1;
  logic [B-1:0] dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, in_hs, out_hs;
  logic [CNT_W-1:0] cnt_q;
  logic [OPC_W-1:0] opc;
  logic [IMM_W-1:0] raw;
  assign opc = in_instr[INSTR_W-1 -: OPC_W];
  assign raw = in_instr[IMM_W-1:0];
  // bundle layout matches the output concatenation below
  assign dec = {opc, in_instr[INSTR_W-OPC_W-1 -: 3*REG_W],
                imm_signed ? XLEN'($signed(raw)) : XLEN'(raw),
                in_instr[ADDR_W-1:0], 32'(opc) >= NUM_OPS};
  assign in_hs  = in_valid & rdy_q;
  assign out_hs = main_v_q & out_ready;
  always_comb begin
    main_v_d = flush ? 1'b0 : out_hs ? (skid_v_q | in_hs) : (main_v_q | in_hs);
    skid_v_d = !flush && !out_hs && (skid_v_q || (in_hs && main_v_q));
    main_d   = out_hs ? (skid_v_q ? skid_q : dec) : (main_v_q ? main_q : dec);
    skid_d   = skid_v_q ? skid_q : dec;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      cnt_q    <= cnt_q + CNT_W'(out_hs);
    end
  end
  assign {opcode, rd, rs1, rs2, imm, addr, illegal} = main_q;
  assign in_ready  = rdy_q;
  assign out_valid = main_v_q;
  assign dec_count = cnt_q;
endmodule
